// File: rtl/alu_issue_unit.sv
// Issue/retire stage around the combinational 32-bit ALU: registers one op per handshake,
// captures result and flags after one execute cycle, and holds the result for writeback.
module alu_issue_unit #(
    parameter int          DATA_W      = 32,
    parameter int          RD_W        = 5,
    parameter logic [7:0]  FLAGS_RESET = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [15:0]       req_imm,
    input  logic              req_use_imm,
    input  logic [RD_W-1:0]   req_rd,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [5:0]        alu_op,
    output logic [7:0]        alu_flags_in,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [7:0]        alu_flags_out,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic              wb_we,
    output logic [RD_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              illegal_op,
    output logic [7:0]        flags_q,
    output logic [31:0]       ops_retired,
    output logic [1:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // req_ready is combinational (IDLE, or WB with wb_ready) and is forced low by flush;
    // wb_valid is high exactly while in WB and the wb_* payload is stable until wb_ready.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    localparam logic [5:0] OP_CMP  = 6'h0B;
    localparam logic [5:0] OP_CMPI = 6'h0F;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [5:0]          alu_op_q, alu_op_d;
    logic [RD_W-1:0]     rd_q, rd_d;
    logic                wb_we_q, wb_we_d;
    logic [RD_W-1:0]     wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic                illegal_q, illegal_d;
    logic [7:0]          flags_d;
    logic [7:0]          flags_r;
    logic [31:0]         retired_q, retired_d;
    logic                req_ready_c;
    logic                op_illegal;
    logic                op_no_write;
    logic [DATA_W-1:0]   b_mux;

    assign op_illegal  = (alu_op_q[5:4] != 2'b00);
    assign op_no_write = op_illegal || (alu_op_q == OP_CMP) || (alu_op_q == OP_CMPI);
    assign b_mux       = req_use_imm ? {{(DATA_W-16){req_imm[15]}}, req_imm} : req_b;

    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rd_d        = rd_q;
        wb_we_d     = wb_we_q;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        illegal_d   = 1'b0;
        flags_d     = flags_r;
        retired_d   = retired_q;
        req_ready_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready_c = !flush;
                if (req_valid && !flush) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    wb_data_d = op_illegal ? '0 : alu_result;
                    wb_rd_d   = rd_q;
                    wb_we_d   = !op_no_write;
                    illegal_d = op_illegal;
                    if (!op_illegal) begin
                        flags_d = alu_flags_out;
                    end
                    state_d = S_WB;
                end
            end
            S_WB: begin
                req_ready_c = wb_ready && !flush;
                if (flush) begin
                    state_d = S_IDLE;
                end else if (wb_ready) begin
                    retired_d = retired_q + 32'd1;
                    state_d   = req_valid ? S_EXEC : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new op is latched on any accepted request, from IDLE or back-to-back from WB.
        if (req_valid && req_ready_c) begin
            alu_a_d  = req_a;
            alu_b_d  = b_mux;
            alu_op_d = req_op;
            rd_d     = req_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            rd_q      <= '0;
            wb_we_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            illegal_q <= 1'b0;
            flags_r   <= FLAGS_RESET;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            rd_q      <= rd_d;
            wb_we_q   <= wb_we_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            illegal_q <= illegal_d;
            flags_r   <= flags_d;
            retired_q <= retired_d;
        end
    end

    assign req_ready    = req_ready_c;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_op       = alu_op_q;
    assign alu_flags_in = flags_r;
    assign wb_valid     = (state_q == S_WB);
    assign wb_we        = wb_we_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign illegal_op   = illegal_q;
    assign flags_q      = flags_r;
    assign ops_retired  = retired_q;
    assign dbg_state    = state_q;

endmodule
